// File: rtl/io_intr_unit.sv
// Registered I/O ports, halt flag and a maskable fixed-priority interrupt controller.
// IRQ line to intr_flag is 4 edges; no backpressure. `define IO_IRQ_EDGE_EN latches rising edges instead of levels.
module io_intr_unit #(
   parameter int DATA_W    = 8,
   parameter int N_IN      = 2,
   parameter int N_OUT     = 2,
   parameter int N_IRQ     = 4,
   parameter int SEL_IN_W  = (N_IN  > 1) ? $clog2(N_IN)  : 1,
   parameter int SEL_OUT_W = (N_OUT > 1) ? $clog2(N_OUT) : 1,
   parameter int VEC_W     = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_IN*DATA_W-1:0]  in_port,
   input  logic [SEL_IN_W-1:0]     in_sel,
   output logic [DATA_W-1:0]       data_to_cpu,
   input  logic                    out_en,
   input  logic [SEL_OUT_W-1:0]    out_sel,
   input  logic [DATA_W-1:0]       data_from_cpu,
   output logic [N_OUT*DATA_W-1:0] out_port,
   input  logic                    HLT_en,
   output logic                    HLT_flag,
   input  logic [N_IRQ-1:0]        irq,
   input  logic                    mask_wr,
   input  logic [N_IRQ-1:0]        mask_in,
   input  logic                    intr_clear,
   output logic                    intr_flag,
   output logic [VEC_W-1:0]        intr_vec,
   output logic [N_IRQ-1:0]        irq_pending
);

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

   logic [DATA_W-1:0] in_q  [N_IN];
   logic [DATA_W-1:0] out_q [N_OUT];
   logic [N_IRQ-1:0]  s1_q, s2_q;
   logic [N_IRQ-1:0]  pending_q, pending_d;
   logic [N_IRQ-1:0]  mask_q;
   logic [N_IRQ-1:0]  req, set, clr;
   logic [VEC_W-1:0]  vec_q, vec_d, sel_idx;
   logic              hlt_q, hlt_d;
   state_t            state_q, state_d;

`ifdef IO_IRQ_EDGE_EN
   logic [N_IRQ-1:0]  s3_q;

   always_ff @(posedge clk) begin
      if (rst) s3_q <= '0;
      else     s3_q <= s2_q;
   end

   assign set = s2_q & ~s3_q;
`else
   assign set = s2_q;
`endif

   assign req = pending_q & mask_q;

   always_comb begin
      data_to_cpu = '0;
      for (int i = 0; i < N_IN; i++) begin
         if (in_sel == SEL_IN_W'(i)) data_to_cpu = in_q[i];
      end
   end

   always_comb begin
      out_port = '0;
      for (int i = 0; i < N_OUT; i++) begin
         out_port[i*DATA_W +: DATA_W] = out_q[i];
      end
   end

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      hlt_d   = hlt_q;
      clr     = '0;
      sel_idx = '0;
      // Descending scan so the lowest requesting index wins.
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (req[i]) sel_idx = VEC_W'(i);
      end
      unique case (state_q)
         IDLE: begin
            if (|req) begin
               state_d = ACTIVE;
               vec_d   = sel_idx;
            end
         end
         ACTIVE: begin
            if (intr_clear) begin
               state_d = IDLE;
               for (int i = 0; i < N_IRQ; i++) begin
                  if (vec_q == VEC_W'(i)) clr[i] = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      pending_d = (pending_q & ~clr) | set;
      if (state_q == IDLE && |req) hlt_d = 1'b0;
      else if (HLT_en)             hlt_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_IN; i++)  in_q[i]  <= '0;
         for (int i = 0; i < N_OUT; i++) out_q[i] <= '0;
         s1_q      <= '0;
         s2_q      <= '0;
         pending_q <= '0;
         mask_q    <= '1;
         vec_q     <= '0;
         hlt_q     <= 1'b0;
         state_q   <= IDLE;
      end else begin
         for (int i = 0; i < N_IN; i++) in_q[i] <= in_port[i*DATA_W +: DATA_W];
         if (out_en) begin
            for (int i = 0; i < N_OUT; i++) begin
               if (out_sel == SEL_OUT_W'(i)) out_q[i] <= data_from_cpu;
            end
         end
         s1_q      <= irq;
         s2_q      <= s1_q;
         pending_q <= pending_d;
         if (mask_wr) mask_q <= mask_in;
         vec_q     <= vec_d;
         hlt_q     <= hlt_d;
         state_q   <= state_d;
      end
   end

   assign HLT_flag    = hlt_q;
   assign intr_flag   = (state_q == ACTIVE);
   assign intr_vec    = vec_q;
   assign irq_pending = pending_q;

endmodule

// File: tb/tb_io_intr_unit.sv
// Directed bench for io_intr_unit: port/halt vector table plus interrupt sequences.
module tb_io_intr_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] in_port;
   logic [0:0]  in_sel;
   logic [7:0]  data_to_cpu;
   logic        out_en;
   logic [0:0]  out_sel;
   logic [7:0]  data_from_cpu;
   logic [15:0] out_port;
   logic        HLT_en;
   logic        HLT_flag;
   logic [3:0]  irq;
   logic        mask_wr;
   logic [3:0]  mask_in;
   logic        intr_clear;
   logic        intr_flag;
   logic [1:0]  intr_vec;
   logic [3:0]  irq_pending;

   int tests = 0;
   int fails = 0;

   io_intr_unit dut (
      .clk(clk), .rst(rst),
      .in_port(in_port), .in_sel(in_sel), .data_to_cpu(data_to_cpu),
      .out_en(out_en), .out_sel(out_sel), .data_from_cpu(data_from_cpu),
      .out_port(out_port), .HLT_en(HLT_en), .HLT_flag(HLT_flag),
      .irq(irq), .mask_wr(mask_wr), .mask_in(mask_in), .intr_clear(intr_clear),
      .intr_flag(intr_flag), .intr_vec(intr_vec), .irq_pending(irq_pending)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] in_port;
      logic        in_sel;
      logic        out_en;
      logic        out_sel;
      logic [7:0]  data;
      logic        hlt_en;
      logic [7:0]  exp_data;
      logic [15:0] exp_out;
      logic        exp_hlt;
   } vec_t;

   vec_t tbl [7];

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_irq(input string tag, input logic flag, input logic [1:0] vec);
      check({tag, " intr_flag"}, 32'(intr_flag), 32'(flag));
      if (flag) check({tag, " intr_vec"}, 32'(intr_vec), 32'(vec));
   endtask

   initial begin
      //          in_port   sel oen osel data   hlt  exp_d  exp_out   exp_h
      tbl[0] = '{16'hB2A1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'hB2, 16'h0000, 1'b0};
      tbl[1] = '{16'hB2A1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'hA1, 16'h0000, 1'b0};
      tbl[2] = '{16'h1234, 1'b0, 1'b1, 1'b1, 8'h5C, 1'b0, 8'h34, 16'h5C00, 1'b0};
      tbl[3] = '{16'h1234, 1'b1, 1'b1, 1'b0, 8'h77, 1'b0, 8'h12, 16'h5C77, 1'b0};
      tbl[4] = '{16'h0000, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 8'h00, 16'h5C77, 1'b0};
      tbl[5] = '{16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 16'h5C77, 1'b1};
      tbl[6] = '{16'hC3C3, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'hC3, 16'h5C00, 1'b1};

      rst = 1'b1; in_port = '0; in_sel = '0; out_en = 1'b0; out_sel = '0;
      data_from_cpu = '0; HLT_en = 1'b0; irq = '0; mask_wr = 1'b0;
      mask_in = '0; intr_clear = 1'b0;
      @(negedge clk);
      tick();
      rst = 1'b0;
      mask_wr = 1'b1; mask_in = 4'hF;
      tick();
      mask_wr = 1'b0;
      check("rst data_to_cpu", 32'(data_to_cpu), 32'h0);
      check("rst out_port",    32'(out_port),    32'h0);
      check("rst HLT_flag",    32'(HLT_flag),    32'h0);
      check("rst intr_flag",   32'(intr_flag),   32'h0);
      check("rst intr_vec",    32'(intr_vec),    32'h0);
      check("rst irq_pending", 32'(irq_pending), 32'h0);

      for (int i = 0; i < 7; i++) begin
         in_port = tbl[i].in_port; in_sel = tbl[i].in_sel; out_en = tbl[i].out_en;
         out_sel = tbl[i].out_sel; data_from_cpu = tbl[i].data; HLT_en = tbl[i].hlt_en;
         tick();
         check($sformatf("vec%0d data_to_cpu", i), 32'(data_to_cpu), 32'(tbl[i].exp_data));
         check($sformatf("vec%0d out_port", i),    32'(out_port),    32'(tbl[i].exp_out));
         check($sformatf("vec%0d HLT_flag", i),    32'(HLT_flag),    32'(tbl[i].exp_hlt));
      end
      out_en = 1'b0; HLT_en = 1'b0;

      // Clear halt left over from the table before the interrupt sequences.
      rst = 1'b1; tick(); rst = 1'b0;
      check("rst2 HLT_flag", 32'(HLT_flag), 32'h0);

      // Priority: lines 1 and 3 together, held 3 edges.
      irq = 4'b1010;
      tick(); tick(); tick();
      irq = 4'b0000;
      check("prio pending", 32'(irq_pending), 32'hA);
      chk_irq("prio early", 1'b0, 2'd0);
      tick();
      chk_irq("prio first", 1'b1, 2'd1);
      tick();
      chk_irq("prio hold", 1'b1, 2'd1);
      intr_clear = 1'b1; tick(); intr_clear = 1'b0;
      chk_irq("prio ack gap", 1'b0, 2'd0);
      check("prio pending after ack", 32'(irq_pending), 32'h8);
      tick();
      chk_irq("prio second", 1'b1, 2'd3);
      intr_clear = 1'b1; tick(); intr_clear = 1'b0;
      check("prio pending drained", 32'(irq_pending), 32'h0);
      intr_clear = 1'b1; tick(); intr_clear = 1'b0;
      chk_irq("idle clear ignored", 1'b0, 2'd0);

      // Masking gates selection but not latching.
      mask_wr = 1'b1; mask_in = 4'b1101; tick(); mask_wr = 1'b0;
      irq = 4'b0010; tick(); irq = 4'b0000;
      tick(); tick();
      check("mask pending", 32'(irq_pending), 32'h2);
      tick(); tick();
      chk_irq("mask blocked", 1'b0, 2'd0);
      mask_wr = 1'b1; mask_in = 4'hF; tick(); mask_wr = 1'b0;
      chk_irq("mask write edge", 1'b0, 2'd0);
      tick();
      chk_irq("mask released", 1'b1, 2'd1);
      intr_clear = 1'b1; tick(); intr_clear = 1'b0;
      check("mask pending cleared", 32'(irq_pending), 32'h0);

      // Halt and wake-on-interrupt.
      HLT_en = 1'b1; tick(); HLT_en = 1'b0;
      check("halt set", 32'(HLT_flag), 32'h1);
      irq = 4'b0100; tick(); irq = 4'b0000;
      tick(); tick();
      check("halt held", 32'(HLT_flag), 32'h1);
      tick();
      chk_irq("wake irq", 1'b1, 2'd2);
      check("wake HLT_flag", 32'(HLT_flag), 32'h0);
      intr_clear = 1'b1; tick(); intr_clear = 1'b0;
      irq = 4'b0001; tick(); irq = 4'b0000;
      tick(); tick();
      HLT_en = 1'b1; tick(); HLT_en = 1'b0;
      chk_irq("coincident irq", 1'b1, 2'd0);
      check("coincident HLT_flag", 32'(HLT_flag), 32'h0);
      tick();
      check("coincident HLT hold", 32'(HLT_flag), 32'h0);
      intr_clear = 1'b1; tick(); intr_clear = 1'b0;
      chk_irq("coincident ack", 1'b0, 2'd0);

      // Line 0 held high across the acknowledge.
      irq = 4'b0001;
      tick(); tick(); tick(); tick(); tick();
      chk_irq("mode first", 1'b1, 2'd0);
      intr_clear = 1'b1; tick(); intr_clear = 1'b0;
      chk_irq("mode ack", 1'b0, 2'd0);
      tick(); tick();
`ifdef IO_IRQ_EDGE_EN
      chk_irq("mode after ack", 1'b0, 2'd0);
`else
      chk_irq("mode after ack", 1'b1, 2'd0);
`endif
      irq = 4'b0000;
      tick(); tick();
      intr_clear = 1'b1; tick(); intr_clear = 1'b0;
      tick();
      chk_irq("mode settled", 1'b0, 2'd0);
      check("mode pending", 32'(irq_pending), 32'h0);

      // Reset mid-service, with mask cleared meanwhile.
      irq = 4'b1000; tick(); irq = 4'b0000;
      tick(); tick(); tick();
      chk_irq("midrst active", 1'b1, 2'd3);
      mask_wr = 1'b1; mask_in = 4'h0; tick(); mask_wr = 1'b0;
      chk_irq("midrst mask ignored", 1'b1, 2'd3);
      rst = 1'b1; tick(); rst = 1'b0;
      chk_irq("midrst flag", 1'b0, 2'd0);
      check("midrst vec", 32'(intr_vec), 32'h0);
      check("midrst pending", 32'(irq_pending), 32'h0);
      irq = 4'b1000; tick(); irq = 4'b0000;
      tick(); tick(); tick();
      chk_irq("midrst mask restored", 1'b1, 2'd3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
